// File: rtl/fib_regfile_checker.sv
// Scans the register file after the Fibonacci writer has filled it and checks
// r0/r1 against their seeds and every later register against the sum of the two before it.
module fib_regfile_checker #(
  parameter logic [15:0] F0_INIT  = 16'd1,
  parameter logic [15:0] F1_INIT  = 16'd2,
  parameter int          NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_en,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        err_flag,
  output logic [3:0]  first_err_idx,
  output logic [15:0] last_value
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS - 1);
  localparam logic [4:0] ERR_MAX   = 5'd31;

  logic [1:0]  state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic        vld_q, vld_d;
  logic [3:0]  chk_idx_q, chk_idx_d;
  logic [15:0] prev1_q, prev1_d;
  logic [15:0] prev2_q, prev2_d;
  logic [4:0]  err_count_q, err_count_d;
  logic        err_flag_q, err_flag_d;
  logic [3:0]  first_err_idx_q, first_err_idx_d;
  logic [15:0] last_value_q, last_value_d;

  logic        accept;
  logic [15:0] chain_sum;
  logic [15:0] expected;
  logic        mismatch;

  // The chain check uses the values actually read, so one bad register flags
  // itself and the two sums that depend on it; the carry out is dropped on purpose.
  assign chain_sum = prev1_q + prev2_q;
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    expected = chain_sum;
    case (chk_idx_q)
      4'd0:    expected = F0_INIT;
      4'd1:    expected = F1_INIT;
      default: expected = chain_sum;
    endcase
  end

  assign mismatch = vld_q && (rd_data != expected);

  always_comb begin
    state_d         = state_q;
    rd_en_d         = rd_en_q;
    rd_addr_d       = rd_addr_q;
    vld_d           = rd_en_q;
    chk_idx_d       = rd_addr_q;
    prev1_d         = prev1_q;
    prev2_d         = prev2_q;
    err_count_d     = err_count_q;
    err_flag_d      = err_flag_q;
    first_err_idx_d = first_err_idx_q;
    last_value_d    = last_value_q;

    if (vld_q) begin
      prev2_d      = prev1_q;
      prev1_d      = rd_data;
      last_value_d = rd_data;
      if (mismatch) begin
        if (err_count_q != ERR_MAX) begin
          err_count_d = err_count_q + 5'd1;
        end
        if (!err_flag_q) begin
          err_flag_d      = 1'b1;
          first_err_idx_d = chk_idx_q;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d         = S_READ;
          rd_en_d         = 1'b1;
          rd_addr_d       = 4'd0;
          err_count_d     = 5'd0;
          err_flag_d      = 1'b0;
          first_err_idx_d = 4'd0;
        end
      end
      S_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 4'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= 4'd0;
      vld_q           <= 1'b0;
      chk_idx_q       <= 4'd0;
      prev1_q         <= 16'd0;
      prev2_q         <= 16'd0;
      err_count_q     <= 5'd0;
      err_flag_q      <= 1'b0;
      first_err_idx_q <= 4'd0;
      last_value_q    <= 16'd0;
    end else begin
      state_q         <= state_d;
      rd_en_q         <= rd_en_d;
      rd_addr_q       <= rd_addr_d;
      vld_q           <= vld_d;
      chk_idx_q       <= chk_idx_d;
      prev1_q         <= prev1_d;
      prev2_q         <= prev2_d;
      err_count_q     <= err_count_d;
      err_flag_q      <= err_flag_d;
      first_err_idx_q <= first_err_idx_d;
      last_value_q    <= last_value_d;
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign busy          = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_count_q == 5'd0);
  assign err_count     = err_count_q;
  assign err_flag      = err_flag_q;
  assign first_err_idx = first_err_idx_q;
  assign last_value    = last_value_q;

endmodule
